// File: rtl/alu_pkg.sv
// Shared opcode, ALU control and sequencer state definitions for the execute stage.
// Decode imports the same opcode constants.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h01;
    localparam logic [5:0] OP_MUL = 6'h02;
    localparam logic [5:0] OP_LDB = 6'h10;
    localparam logic [5:0] OP_LDW = 6'h11;
    localparam logic [5:0] OP_STB = 6'h12;
    localparam logic [5:0] OP_STW = 6'h13;

    localparam logic [1:0] ALU_CTRL_ADD = 2'b00;
    localparam logic [1:0] ALU_CTRL_SUB = 2'b01;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StExec    = 2'd1,
        StMulIter = 2'd2,
        StDone    = 2'd3
    } state_e;

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_STB, OP_STW};
    endfunction

    // Memory ops only need the address add, so everything but SUB maps to ADD.
    function automatic logic [1:0] op_ctrl(input logic [5:0] op);
        return (op == OP_SUB) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
    endfunction

endpackage

// File: rtl/mul_shift_regs.sv
// Accumulator, shifting multiplicand/multiplier and iteration counter for the
// shift-add multiply. Priority: clear, then load, then step.
module mul_shift_regs #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    input  logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] mcand,
    output logic             mplier_lsb,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] mplier_q;

    assign mplier_lsb = mplier_q[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            mcand    <= '0;
            mplier_q <= '0;
            cnt      <= '0;
        end else if (clear) begin
            acc      <= '0;
            mcand    <= '0;
            mplier_q <= '0;
            cnt      <= '0;
        end else if (load) begin
            acc      <= '0;
            mcand    <= load_a;
            mplier_q <= load_b;
            cnt      <= CNT_W'(WIDTH);
        end else if (step) begin
            acc      <= sum;
            mcand    <= mcand << 1;
            mplier_q <= mplier_q >> 1;
            cnt      <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Execute-stage controller owning the shared external ALU: single-pass ADD/SUB/address ops,
// WIDTH-iteration shift-add MUL, and a result held until the consumer takes it.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal,
    output logic             busy
);

    state_e           state_q;
    logic [5:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             accept;
    logic             mul_load;
    logic             mul_step;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic             mplier_lsb;
    logic [CNT_W-1:0] cnt;

    // Gate with reset so nothing looks acceptable while reset is held.
    assign in_ready  = (state_q == StIdle) && reset;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign accept    = in_valid && in_ready && !flush;
    assign mul_load  = accept && (opcode == OP_MUL);
    assign mul_step  = (state_q == StMulIter) && !flush;

    mul_shift_regs #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul_regs (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .load       (mul_load),
        .step       (mul_step),
        .load_a     (operand_a),
        .load_b     (operand_b),
        .sum        (alu_result),
        .acc        (acc),
        .mcand      (mcand),
        .mplier_lsb (mplier_lsb),
        .cnt        (cnt)
    );

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_CTRL_ADD;
        unique case (state_q)
            StExec: begin
                alu_a    = a_q;
                alu_b    = b_q;
                alu_ctrl = op_ctrl(op_q);
            end
            StMulIter: begin
                alu_a = acc;
                alu_b = mplier_lsb ? mcand : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            result  <= '0;
            illegal <= 1'b0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q <= opcode;
                        a_q  <= operand_a;
                        b_q  <= operand_b;
                        if (!op_legal(opcode)) begin
                            result  <= '0;
                            illegal <= 1'b1;
                            state_q <= StDone;
                        end else if (opcode == OP_MUL) begin
                            state_q <= StMulIter;
                        end else begin
                            state_q <= StExec;
                        end
                    end
                end
                StExec: begin
                    result  <= alu_result;
                    illegal <= 1'b0;
                    state_q <= StDone;
                end
                StMulIter: begin
                    // Last of the WIDTH passes: the adder output is the final product.
                    if (cnt == CNT_W'(1)) begin
                        result  <= alu_result;
                        illegal <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a behavioural result/latency model
// and a simple combinational ALU standing in for the external one.
module tb_alu_op_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   opcode;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic [W-1:0] alu_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         illegal;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign alu_result = (alu_ctrl == 2'b01) ? alu_a - alu_b : alu_a + alu_b;

    alu_op_sequencer #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .illegal    (illegal),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Latency counts edges after the accept edge until out_valid is seen.
    task automatic model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic ill, output int lat,
                         output logic [1:0] ctrl);
        ill  = 1'b0;
        lat  = 1;
        ctrl = 2'b00;
        case (op)
            6'h00, 6'h10, 6'h11, 6'h12, 6'h13: res = a + b;
            6'h01: begin
                res  = a - b;
                ctrl = 2'b01;
            end
            6'h02: begin
                res = a * b;
                lat = W;
            end
            default: begin
                res = '0;
                ill = 1'b1;
                lat = 0;
            end
        endcase
    endtask

    task automatic run_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        logic [W-1:0] exp_res;
        logic         exp_ill;
        int           exp_lat;
        logic [1:0]   exp_ctrl;
        int           k;
        model(op, a, b, exp_res, exp_ill, exp_lat, exp_ctrl);
        check("in_ready_idle", in_ready, 1);
        opcode    = op;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        opcode    = 6'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
        if (!exp_ill) begin
            check("first_ctrl", alu_ctrl, exp_ctrl);
            check("first_alu_a", alu_a, (op == 6'h02) ? '0 : a);
            check("first_alu_b", alu_b, (op == 6'h02) ? (b[0] ? a : '0) : b);
            check("busy", busy, 1);
        end
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", k, exp_lat);
        check("result", result, exp_res);
        check("illegal", illegal, exp_ill);
        check("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, exp_res);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_busy", busy, 0);
    endtask

    task automatic start_mul_10(input logic [W-1:0] a, input logic [W-1:0] b);
        opcode    = 6'h02;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] op;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic seen;
        ops = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12, 6'h13, 6'h3F};

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_illegal", illegal, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_alu_a", alu_a, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_result", result, 0);

        run_op(6'h00, 32'd5, 32'd7, 0);
        run_op(6'h01, 32'd3, 32'd5, 0);
        run_op(6'h11, 32'h100, 32'h8, 0);
        run_op(6'h02, 32'h0000_FFFF, 32'h0001_0001, 0);
        run_op(6'h02, 32'h0, 32'hDEAD_BEEF, 1);
        run_op(6'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(6'h00, 32'hFFFF_FFFF, 32'h1, 5);
        run_op(6'h3F, 32'h1234, 32'h5678, 2);

        // flush in IDLE competing with in_valid must not accept
        opcode   = 6'h00;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_busy", busy, 0);
        check("flush_idle_in_ready", in_ready, 1);

        start_mul_10(32'h1234_5678, 32'h9ABC_DEF1);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_busy", busy, 0);
        check("flush_alu_a", alu_a, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_valid", seen, 0);
        run_op(6'h00, 32'd100, 32'd23, 0);

        start_mul_10(32'h0000_0003, 32'h0000_0007);
        #3;
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_result", result, 0);
        check("arst_alu_ctrl", alu_ctrl, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("arst_no_valid", seen, 0);
        run_op(6'h00, 32'd40, 32'd2, 0);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(7, 0)];
            if (op == 6'h3F) op = 6'($urandom_range(63, 20));
            ra = (i % 3 == 0) ? 32'($urandom_range(255, 0)) : $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(255, 0)) : $urandom;
            run_op(op, ra, rb, $urandom_range(3, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
